// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing the Packetizer AXIS input between the PN
// generator (source 0) and the user payload path (source 1), one whole frame per grant.
module tx_frame_scheduler #(
    parameter int unsigned  BYTES      = 1,
    parameter int unsigned  GAP_CYCLES = 16,
    parameter logic [15:0]  MAX_BEATS  = 16'd4096,
    localparam int unsigned BITS       = BYTES * 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,

    input  logic [BITS-1:0] s0_tdata,
    input  logic            s0_tvalid,
    output logic            s0_tready,
    input  logic            s0_tlast,
    input  logic            s0_tuser,

    input  logic [BITS-1:0] s1_tdata,
    input  logic            s1_tvalid,
    output logic            s1_tready,
    input  logic            s1_tlast,
    input  logic            s1_tuser,

    output logic [BITS-1:0] m_tdata,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic            m_tlast,
    output logic            m_tuser,

    input  logic            tx_done,
    output logic            pkt_sent0,
    output logic            pkt_sent1,
    output logic            grant,
    output logic            busy,
    output logic [15:0]     frame_cnt,
    output logic            err_trunc
);

    localparam int unsigned CNT_W    = 16;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             last_grant;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] gap_cnt;

    logic sel_valid;
    logic sel_last;
    logic force_last;
    logic in_xfer;
    logic hs;
    logic end_beat;
    logic start;
    logic pick;

    // Granted-source selection, handshake and arbitration decode
    always_comb begin
        sel_valid  = grant ? s1_tvalid : s0_tvalid;
        sel_last   = grant ? s1_tlast  : s0_tlast;
        force_last = (beat_cnt == (MAX_BEATS - 16'd1));
        in_xfer    = (state_q == ST_XFER);
        hs         = in_xfer & sel_valid & m_tready;
        end_beat   = hs & (sel_last | force_last);
        start      = (state_q == ST_IDLE) & en & (s0_tvalid | s1_tvalid);
        // On a tie the source that did not own the previous frame wins
        pick       = (s0_tvalid & s1_tvalid) ? ~last_grant : s1_tvalid;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (end_beat) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt <= 16'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Zero-latency AXIS pass-through, gated to the XFER state
    always_comb begin
        m_tdata   = grant ? s1_tdata : s0_tdata;
        m_tuser   = grant ? s1_tuser : s0_tuser;
        m_tlast   = sel_last | force_last;
        m_tvalid  = in_xfer & sel_valid;
        s0_tready = in_xfer & ~grant & m_tready;
        s1_tready = in_xfer &  grant & m_tready;
    end

    // Grant, counters and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            busy       <= 1'b0;
            pkt_sent0  <= 1'b0;
            pkt_sent1  <= 1'b0;
            frame_cnt  <= '0;
            err_trunc  <= 1'b0;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            pkt_sent0 <= 1'b0;
            pkt_sent1 <= 1'b0;
            err_trunc <= 1'b0;
            busy      <= (state_d != ST_IDLE);
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        grant      <= pick;
                        last_grant <= pick;
                        beat_cnt   <= '0;
                    end
                end
                ST_XFER: begin
                    if (hs) begin
                        beat_cnt  <= beat_cnt + 16'd1;
                        // Guard ended the frame while the source still had beats
                        err_trunc <= force_last & ~sel_last;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        pkt_sent0 <= ~grant;
                        pkt_sent1 <= grant;
                        frame_cnt <= frame_cnt + 16'd1;
                        gap_cnt   <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Randomized bench for tx_frame_scheduler: a transaction/timestamp reference model
// checks every cycle, plus a directed zero-gap instance.
module tb_tx_frame_scheduler;

    localparam int unsigned GAP  = 5;
    localparam logic [15:0] MAXB = 16'd8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, tx_done, m_tready;
    logic [7:0] s0_tdata, s1_tdata, m_tdata;
    logic       s0_tvalid, s0_tready, s0_tlast, s0_tuser;
    logic       s1_tvalid, s1_tready, s1_tlast, s1_tuser;
    logic       m_tvalid, m_tlast, m_tuser;
    logic       pkt_sent0, pkt_sent1, grant, busy, err_trunc;
    logic [15:0] frame_cnt;

    tx_frame_scheduler #(.BYTES(1), .GAP_CYCLES(GAP), .MAX_BEATS(MAXB)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s0_tlast(s0_tlast), .s0_tuser(s0_tuser),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .s1_tlast(s1_tlast), .s1_tuser(s1_tuser),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .tx_done(tx_done), .pkt_sent0(pkt_sent0), .pkt_sent1(pkt_sent1),
        .grant(grant), .busy(busy), .frame_cnt(frame_cnt), .err_trunc(err_trunc)
    );

    // Zero-gap instance with the default frame guard
    logic       z_en, z_tx_done, z_m_tready;
    logic [7:0] z_s0_tdata, z_s1_tdata, z_m_tdata;
    logic       z_s0_tvalid, z_s0_tready, z_s0_tlast, z_s0_tuser;
    logic       z_s1_tvalid, z_s1_tready, z_s1_tlast, z_s1_tuser;
    logic       z_m_tvalid, z_m_tlast, z_m_tuser;
    logic       z_pkt0, z_pkt1, z_grant, z_busy, z_trunc;
    logic [15:0] z_cnt;

    tx_frame_scheduler #(.BYTES(1), .GAP_CYCLES(0), .MAX_BEATS(16'd4096)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .en(z_en),
        .s0_tdata(z_s0_tdata), .s0_tvalid(z_s0_tvalid), .s0_tready(z_s0_tready),
        .s0_tlast(z_s0_tlast), .s0_tuser(z_s0_tuser),
        .s1_tdata(z_s1_tdata), .s1_tvalid(z_s1_tvalid), .s1_tready(z_s1_tready),
        .s1_tlast(z_s1_tlast), .s1_tuser(z_s1_tuser),
        .m_tdata(z_m_tdata), .m_tvalid(z_m_tvalid), .m_tready(z_m_tready),
        .m_tlast(z_m_tlast), .m_tuser(z_m_tuser),
        .tx_done(z_tx_done), .pkt_sent0(z_pkt0), .pkt_sent1(z_pkt1),
        .grant(z_grant), .busy(z_busy), .frame_cnt(z_cnt), .err_trunc(z_trunc)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       l;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    beat_t cur0 = '0;
    beat_t cur1 = '0;
    bit    hold0 = 1'b0;
    bit    hold1 = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vprob, rprob, dprob, eprob;
    int m_beats   = 0;
    int src_pops  = 0;

    // Reference model: frame ownership, beat count and the time arbitration reopens
    int owner     = 0;
    bit last_g    = 1'b1;
    bit in_frame  = 1'b0;
    bit awaiting  = 1'b0;
    int idle_from = 0;
    int beats     = 0;
    int exp_cnt   = 0;
    bit e_p0 = 1'b0, e_p1 = 1'b0, e_tr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void new_frame(input int i);
        int   len;
        logic u;
        beat_t x;
        len = $urandom_range(12, 1);
        u   = 1'($urandom);
        for (int b = 0; b < len; b++) begin
            x.d = 8'($urandom);
            x.u = u;
            x.l = (b == len - 1);
            if (i == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
    endfunction

    task automatic drive();
        if (!hold0) begin
            if (q0.size() == 0) new_frame(0);
            if ($urandom_range(99) < vprob) begin hold0 = 1'b1; cur0 = q0.pop_front(); end
        end
        if (!hold1) begin
            if (q1.size() == 0) new_frame(1);
            if ($urandom_range(99) < vprob) begin hold1 = 1'b1; cur1 = q1.pop_front(); end
        end
        s0_tvalid = hold0; s0_tdata = cur0.d; s0_tuser = cur0.u; s0_tlast = cur0.l;
        s1_tvalid = hold1; s1_tdata = cur1.d; s1_tuser = cur1.u; s1_tlast = cur1.l;
        m_tready  = ($urandom_range(99) < rprob);
        tx_done   = ($urandom_range(99) < dprob);
        en        = ($urandom_range(99) < eprob);
    endtask

    task automatic check_cycle();
        bit busy_e, mv_e, sv_o;
        busy_e = in_frame || awaiting || (cyc < idle_from);
        sv_o   = (owner == 1) ? s1_tvalid : s0_tvalid;
        mv_e   = in_frame && sv_o;
        chk("busy", 32'(busy), 32'(busy_e));
        if (busy_e) chk("grant", 32'(grant), 32'(owner));
        chk("pkt_sent0", 32'(pkt_sent0), 32'(e_p0));
        chk("pkt_sent1", 32'(pkt_sent1), 32'(e_p1));
        chk("err_trunc", 32'(err_trunc), 32'(e_tr));
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("m_tvalid", 32'(m_tvalid), 32'(mv_e));
        chk("s0_tready", 32'(s0_tready), 32'(in_frame && owner == 0 && m_tready));
        chk("s1_tready", 32'(s1_tready), 32'(in_frame && owner == 1 && m_tready));
        if (mv_e) begin
            chk("m_tdata", 32'(m_tdata), 32'((owner == 1) ? s1_tdata : s0_tdata));
            chk("m_tuser", 32'(m_tuser), 32'((owner == 1) ? s1_tuser : s0_tuser));
            chk("m_tlast", 32'(m_tlast),
                32'(((owner == 1) ? s1_tlast : s0_tlast) || (beats == int'(MAXB) - 1)));
        end
    endtask

    task automatic update();
        bit sv_o, sl_o, lastf;
        sv_o = (owner == 1) ? s1_tvalid : s0_tvalid;
        sl_o = (owner == 1) ? s1_tlast  : s0_tlast;
        if (s0_tvalid && s0_tready) begin hold0 = 1'b0; src_pops++; end
        if (s1_tvalid && s1_tready) begin hold1 = 1'b0; src_pops++; end
        if (m_tvalid && m_tready) m_beats++;
        e_p0 = 1'b0; e_p1 = 1'b0; e_tr = 1'b0;
        if (in_frame) begin
            if (sv_o && m_tready) begin
                lastf = sl_o || (beats == int'(MAXB) - 1);
                if (lastf && !sl_o) e_tr = 1'b1;
                beats++;
                if (lastf) begin in_frame = 1'b0; awaiting = 1'b1; end
            end
        end else if (awaiting) begin
            if (tx_done) begin
                if (owner == 0) e_p0 = 1'b1;
                else            e_p1 = 1'b1;
                exp_cnt   = (exp_cnt + 1) % 65536;
                awaiting  = 1'b0;
                idle_from = cyc + 1 + int'(GAP);
            end
        end else if (cyc >= idle_from && en && (s0_tvalid || s1_tvalid)) begin
            owner    = (s0_tvalid && s1_tvalid) ? (last_g ? 0 : 1) : (s1_tvalid ? 1 : 0);
            last_g   = (owner == 1);
            in_frame = 1'b1;
            beats    = 0;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            drive();
            #1;
            check_cycle();
            update();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, b, pulses;
        rst_n = 1'b0; en = 1'b0; tx_done = 1'b0; m_tready = 1'b0;
        s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0; s0_tuser = 1'b0;
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0; s1_tuser = 1'b0;
        z_en = 1'b1; z_tx_done = 1'b0; z_m_tready = 1'b0;
        z_s0_tvalid = 1'b0; z_s0_tdata = '0; z_s0_tlast = 1'b0; z_s0_tuser = 1'b0;
        z_s1_tvalid = 1'b0; z_s1_tdata = '0; z_s1_tlast = 1'b0; z_s1_tuser = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err_trunc", 32'(err_trunc), 32'd0);
        chk("rst_pkt_sent", 32'({pkt_sent1, pkt_sent0}), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tready", 32'({s1_tready, s0_tready}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Free-flowing, backpressured, saturated (round robin) and enable-toggling traffic
        vprob = 70;  rprob = 100; dprob = 30; eprob = 100; run(2000);
        rprob = 50;  run(2000);
        vprob = 100; run(1000);
        vprob = 50;  eprob = 60; run(2000);

        // Reset in the middle of a frame
        guard = 0;
        while (!in_frame && guard < 200) begin run(1); guard++; end
        chk("rst_mid_found_frame", 32'(in_frame), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tready", 32'({s1_tready, s0_tready}), 32'd0);
        chk("rst_mid_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_pkt_sent", 32'({pkt_sent1, pkt_sent0}), 32'd0);
        rst_n = 1'b1;
        owner = 0; last_g = 1'b1; in_frame = 1'b0; awaiting = 1'b0;
        idle_from = 0; beats = 0; exp_cnt = 0;
        e_p0 = 1'b0; e_p1 = 1'b0; e_tr = 1'b0;
        eprob = 100; vprob = 70; run(1000);
        chk("beat_conservation", 32'(m_beats), 32'(src_pops));
        vprob = 0; en = 1'b0; tx_done = 1'b0;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;

        // Zero-gap instance: one 68-beat frame from source 0
        b = 0; guard = 0;
        while (b < 68 && guard < 300) begin
            @(negedge clk);
            z_s0_tvalid = 1'b1; z_s0_tdata = 8'(b + 1); z_s0_tlast = (b == 67);
            z_s0_tuser = 1'b1; z_m_tready = 1'b1;
            #1;
            if (z_s0_tready) begin
                chk("z_data", 32'(z_m_tdata), 32'(b + 1));
                chk("z_last", 32'(z_m_tlast), 32'(b == 67));
                chk("z_s1_tready", 32'(z_s1_tready), 32'd0);
                b++;
            end
            guard++;
        end
        chk("z_beats", 32'(b), 32'd68);
        chk("z_grant", 32'(z_grant), 32'd0);
        repeat (4) begin
            @(negedge clk);
            z_s0_tvalid = 1'b0;
        end
        #1;
        chk("z_wait_busy", 32'(z_busy), 32'd1);
        chk("z_wait_no_pkt", 32'(z_pkt0), 32'd0);
        @(negedge clk);
        z_tx_done = 1'b1;
        @(negedge clk);
        z_tx_done = 1'b0;
        #1;
        chk("z_pkt_sent0", 32'(z_pkt0), 32'd1);
        chk("z_pkt_sent1", 32'(z_pkt1), 32'd0);
        chk("z_frame_cnt", 32'(z_cnt), 32'd1);
        chk("z_idle_after_done", 32'(z_busy), 32'd0);
        chk("z_no_trunc", 32'(z_trunc), 32'd0);
        @(negedge clk);
        #1;
        chk("z_pkt_sent0_single", 32'(z_pkt0), 32'd0);

        // Back-to-back single-beat frames, tx_done held high throughout
        pulses = 0;
        for (int i = 1; i <= 301; i++) begin
            @(negedge clk);
            z_s0_tvalid = 1'b1; z_s0_tlast = 1'b1; z_tx_done = 1'b1;
            #1;
            if (z_pkt0) begin
                pulses++;
                chk("z_b2b_idle", 32'(z_busy), 32'd0);
            end
        end
        chk("z_b2b_pulses", 32'(pulses), 32'd100);
        chk("z_b2b_frame_cnt", 32'(z_cnt), 32'd101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Round-robin frame scheduler that shares the transmit Packetizer between two AXIS frame sources: source 0 is the PN test-data generator, source 1 is a user payload path. It locks a grant for one whole frame (first beat through `tlast`) and waits for the Packetizer to report the frame on air. It then returns a one-cycle `pkt_sent` pulse to the owning source and enforces an inter-frame gap before arbitrating again. It sits between the data sources and the Packetizer's AXIS input.

## Interface
- `BYTES`, 1: AXIS data width in bytes; `BITS = BYTES*8`.
- `GAP_CYCLES`, 16: idle cycles between frames, 0..65535.
- `MAX_BEATS`, 16'd4096: frame length guard in beats, at least 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  arbitration enable; low blocks new grants, and a frame already in flight completes.
- `s0_tdata` / `s1_tdata`  in  BITS  source payload.
- `s0_tvalid` / `s1_tvalid`  in  1  source valid.
- `s0_tready` / `s1_tready`  out  1  source ready.
- `s0_tlast` / `s1_tlast`  in  1  last beat of the source frame.
- `s0_tuser` / `s1_tuser`  in  1  is_bpsk flag, passed through.
- `m_tdata`  out  BITS  to the Packetizer.
- `m_tvalid`  out  1  to the Packetizer.
- `m_tready`  in  1  from the Packetizer.
- `m_tlast`  out  1  to the Packetizer.
- `m_tuser`  out  1  to the Packetizer.
- `tx_done`  in  1  one-cycle pulse from the Packetizer: the current frame has been sent.
- `pkt_sent0` / `pkt_sent1`  out  1  one-cycle frame-complete pulse to the owning source.
- `grant`  out  1  index of the owning source; valid while `busy`.
- `busy`  out  1  high in every state except IDLE.
- `frame_cnt`  out  16  number of completed frames; wraps from 0xFFFF to 0.
- `err_trunc`  out  1  one-cycle pulse when a frame is force-terminated at `MAX_BEATS`.

## Operation
- FSM states: IDLE, XFER, WAIT_DONE, GAP.
- **IDLE:** when `en` is high and any `sN_tvalid` is high, register `grant` and go to XFER.
  - Tie-break: the source other than `last_grant` wins.
  - `last_grant` resets to 1, so source 0 wins the first tie.
  - `last_grant` is updated when the grant is taken.
- **XFER datapath:** combinational pass-through, zero latency.
  - `m_tdata`, `m_tuser`: the granted source's signals.
  - `m_tvalid = s[grant]_tvalid`.
  - `s[grant]_tready = m_tready`.
  - The non-granted source's `tready` is 0.
  - Outside XFER: `m_tvalid = 0` and both `tready = 0`; `m_tdata`, `m_tuser` and `m_tlast` are don't-care.
- **Beat counter** (16-bit): cleared on entry to XFER; increments on each handshake (`m_tvalid & m_tready`).
- **Effective last:** `m_tlast = s[grant]_tlast | (beat_cnt == MAX_BEATS-1)`.
  - If the force term ends the frame while the source `tlast` is low, pulse `err_trunc` on that handshake.
  - The source's remaining beats are then treated as a new frame.
- **XFER exit:** the handshake with `m_tlast` high moves to WAIT_DONE.
- **WAIT_DONE:** on `tx_done`:
  - pulse `pkt_sent[grant]` for one cycle;
  - increment `frame_cnt`;
  - go to GAP, loading the gap counter with `GAP_CYCLES`.
  - If `GAP_CYCLES == 0`, go straight to IDLE instead.
- **GAP:** count down; when the counter equals 1, the next state is IDLE.
- `en` is sampled in IDLE only.
- `tx_done` outside WAIT_DONE is ignored. WAIT_DONE has no timeout.
- Changing `en` or `sN_tvalid` mid-frame does not change `grant`.

## Timing
- **Reset values** (`rst_n` low): state IDLE, `grant` 0, `last_grant` 1, `busy` 0, `pkt_sent0/1` 0, `frame_cnt` 0, `err_trunc` 0, beat and gap counters 0.
  - Combinational outputs follow the state: `m_tvalid` 0, `s0/s1_tready` 0.
- **Reset mid-frame:** the frame is abandoned, `tready` drops in the same cycle as reset assertion, and no `pkt_sent` pulse is issued.
- **Grant latency:** `tvalid` seen in IDLE at cycle t gives XFER and `tready` at t+1. The first beat can complete at t+1.
- **Data latency:** zero cycles from source to `m_*`.
- **Frame end:** `tlast` handshake at cycle t → WAIT_DONE at t+1. `tx_done` at cycle d gives:
  - `pkt_sent` high at d+1;
  - `frame_cnt` updated at d+1;
  - GAP at d+1.
- **Gap:** GAP occupies exactly `GAP_CYCLES` cycles (d+1 .. d+`GAP_CYCLES`), so IDLE is reached at d+1+`GAP_CYCLES`. The earliest next grant is one cycle later.
- **`err_trunc`:** registered, high the cycle after the forcing handshake.

## Test plan
- **Single source:** s0 offers a 68-beat frame, `m_tready` = 1, `GAP_CYCLES` = 16, `tx_done` 5 cycles after `tlast`.
  - Expect 68 beats in order, `m_tlast` on beat 68.
  - `pkt_sent0` pulses once, `frame_cnt` = 1.
  - The next grant comes no earlier than 17 cycles after the `pkt_sent0` pulse.
- **Round robin:** s0 and s1 both continuously valid, 4-beat frames.
  - Grant order 0,1,0,1.
  - `m_tuser` tracks each source's `tuser`.
  - No interleaved beats.
- **Backpressure:** random `m_tready` at 50%.
  - Data identical to the source.
  - Source sees `tready` only while granted.
  - No beat lost or duplicated.
- **Truncation:** `MAX_BEATS` = 8, s1 sends 10 beats with `tlast` on beat 10.
  - `m_tlast` on beat 8, one `err_trunc` pulse.
  - Beats 9-10 form a second frame.
  - `frame_cnt` = 2 after two `tx_done` pulses.
- **Enable and reset:**
  - `en` dropped mid-frame → the frame completes and no new grant follows.
  - `rst_n` asserted mid-XFER → `tready` = 0 immediately, `frame_cnt` = 0, no `pkt_sent` pulse.
  - `tx_done` pulsed in IDLE → ignored.
- **Wrap and zero gap:** preload via 65536 short frames with `GAP_CYCLES` = 0.
  - `frame_cnt` wraps to 0.
  - IDLE is re-entered the cycle after each `tx_done`.
